// File: rtl/game_sequencer.sv
// Session controller for the piano-tiles game: sequences IDLE -> COUNTDOWN -> PLAYING -> GAME_OVER,
// drives score clear/increment pulses, tracks lives and hit streak, and keeps the best score.
module game_sequencer #(
    parameter int unsigned LIVES           = 3,
    parameter int unsigned COUNTDOWN_BEATS = 3,
    parameter int unsigned STREAK_W        = 8
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                beat_tick,
    input  logic                key_hit,
    input  logic                song_end,
    input  logic [15:0]         score_bcd,
    output logic                running,
    output logic                score_clear,
    output logic                score_inc,
    output logic [2:0]          lives,
    output logic [STREAK_W-1:0] streak,
    output logic [3:0]          countdown,
    output logic [15:0]         best_bcd,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_COUNTDOWN = 2'b01,
        S_PLAYING   = 2'b10,
        S_GAME_OVER = 2'b11
    } state_t;

    state_t                r_state;
    logic                  r_running;
    logic                  r_score_clear;
    logic                  r_score_inc;
    logic [2:0]            r_lives;
    logic [STREAK_W-1:0]   r_streak;
    logic [3:0]            r_countdown;
    logic [15:0]           r_best;
    logic [1:0]            r_cmp_pipe;
    logic                  w_game_end;

    always_comb begin
        w_game_end = 1'b0;
        if (r_state == S_PLAYING)
            w_game_end = song_end || (beat_tick && !key_hit && (r_lives == 3'd1));
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_running     <= 1'b0;
            r_score_clear <= 1'b0;
            r_score_inc   <= 1'b0;
            r_lives       <= 3'(LIVES);
            r_streak      <= '0;
            r_countdown   <= '0;
            r_best        <= '0;
            r_cmp_pipe    <= '0;
        end else begin
            r_score_clear <= 1'b0;
            r_score_inc   <= 1'b0;
            // Best-score compare runs two edges after entering GAME_OVER so the
            // final increment has landed in score_bcd; independent of later restarts.
            r_cmp_pipe    <= {r_cmp_pipe[0], w_game_end};
            if (r_cmp_pipe[1] && (score_bcd > r_best))
                r_best <= score_bcd;

            case (r_state)
                S_IDLE, S_GAME_OVER: begin
                    if (start) begin
                        r_state       <= S_COUNTDOWN;
                        r_score_clear <= 1'b1;
                        r_lives       <= 3'(LIVES);
                        r_streak      <= '0;
                        r_countdown   <= 4'(COUNTDOWN_BEATS);
                    end
                end
                S_COUNTDOWN: begin
                    if (beat_tick) begin
                        if (r_countdown == 4'd1) begin
                            r_state     <= S_PLAYING;
                            r_running   <= 1'b1;
                            r_countdown <= '0;
                        end else begin
                            r_countdown <= r_countdown - 4'd1;
                        end
                    end
                end
                S_PLAYING: begin
                    if (beat_tick) begin
                        if (key_hit) begin
                            r_score_inc <= 1'b1;
                            if (r_streak != '1)
                                r_streak <= r_streak + STREAK_W'(1);
                        end else begin
                            r_streak <= '0;
                            r_lives  <= r_lives - 3'd1;
                        end
                    end
                    if (w_game_end) begin
                        r_state   <= S_GAME_OVER;
                        r_running <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign state       = r_state;
    assign running     = r_running;
    assign score_clear = r_score_clear;
    assign score_inc   = r_score_inc;
    assign lives       = r_lives;
    assign streak      = r_streak;
    assign countdown   = r_countdown;
    assign best_bcd    = r_best;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed vector table, hand-written corner sequences,
// and randomized play checked against a behavioural game model.
module tb_game_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 1'b0, beat_tick = 1'b0, key_hit = 1'b0, song_end = 1'b0;
    logic [15:0] score_bcd;
    logic        running, score_clear, score_inc;
    logic [2:0]  lives;
    logic [7:0]  streak;
    logic [3:0]  countdown;
    logic [15:0] best_bcd;
    logic [1:0]  state;

    game_sequencer #(.LIVES(3), .COUNTDOWN_BEATS(3), .STREAK_W(8)) dut (
        .CLOCK_50(clk), .reset(rst), .start(start), .beat_tick(beat_tick), .key_hit(key_hit),
        .song_end(song_end), .score_bcd(score_bcd), .running(running), .score_clear(score_clear),
        .score_inc(score_inc), .lives(lives), .streak(streak), .countdown(countdown),
        .best_bcd(best_bcd), .state(state)
    );

    // Score datapath stand-in: BCD counter, optionally overridden with a fixed value.
    logic [15:0] dp_score = '0;
    logic        use_force = 1'b0;
    logic [15:0] force_val = '0;
    assign score_bcd = use_force ? force_val : dp_score;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
                else begin r[d*4 +: 4] = r[d*4 +: 4] + 4'd1; carry = 1'b0; end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (score_clear) dp_score <= '0;
        else if (score_inc) dp_score <= bcd_inc(dp_score);
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural game model: mode 0 idle, 1 countdown, 2 playing, 3 game over.
    int          m_mode = 0, m_cd = 0, m_lives = 3, m_streak = 0, m_inc = 0, m_clr = 0;
    logic [15:0] m_best = '0;
    int          m_cmp_due = -1;
    int          cyc_n = 0;

    task automatic model_step(input int r, input int s, input int bt, input int kh,
                              input int se, input logic [15:0] sc);
        bit over;
        m_inc = 0;
        m_clr = 0;
        if (r != 0) begin
            m_mode = 0; m_cd = 0; m_lives = 3; m_streak = 0; m_best = '0; m_cmp_due = -1;
            return;
        end
        if (cyc_n == m_cmp_due && sc > m_best) m_best = sc;
        if (m_mode == 0 || m_mode == 3) begin
            if (s != 0) begin
                m_mode = 1; m_clr = 1; m_lives = 3; m_streak = 0; m_cd = 3;
            end
        end else if (m_mode == 1) begin
            if (bt != 0) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) m_mode = 2;
            end
        end else begin
            over = (se != 0);
            if (bt != 0) begin
                if (kh != 0) begin
                    m_inc = 1;
                    m_streak = (m_streak < 255) ? m_streak + 1 : 255;
                end else begin
                    m_streak = 0;
                    m_lives = m_lives - 1;
                    if (m_lives == 0) over = 1;
                end
            end
            if (over) begin
                m_mode = 3;
                m_cmp_due = cyc_n + 2;
            end
        end
    endtask

    task automatic cyc(input int r, input int s, input int bt, input int kh, input int se);
        logic [15:0] sc;
        rst = (r != 0); start = (s != 0); beat_tick = (bt != 0);
        key_hit = (kh != 0); song_end = (se != 0);
        sc = score_bcd;
        @(posedge clk);
        cyc_n++;
        model_step(r, s, bt, kh, se, sc);
        @(negedge clk);
        chk("model.state", 32'(state), 32'(m_mode));
        chk("model.countdown", 32'(countdown), 32'(m_cd));
        chk("model.lives", 32'(lives), 32'(m_lives));
        chk("model.streak", 32'(streak), 32'(m_streak));
        chk("model.score_inc", 32'(score_inc), 32'(m_inc));
        chk("model.score_clear", 32'(score_clear), 32'(m_clr));
        chk("model.running", 32'(running), 32'(m_mode == 2));
        chk("model.best_bcd", 32'(best_bcd), 32'(m_best));
    endtask

    typedef struct {
        int st, bt, kh, se;
        int e_state, e_cd, e_lives, e_streak, e_inc, e_clr;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int st, bt, kh, se, es, ecd, el, estr, ei, ec);
        vec_t v;
        v = '{st, bt, kh, se, es, ecd, el, estr, ei, ec};
        tbl.push_back(v);
    endtask

    task automatic play_to_over(input logic [15:0] v);
        force_val = v;
        use_force = 1'b1;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (3) begin cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0); end
        cyc(0, 0, 0, 0, 1);
        chk("t4.game_over", 32'(state), 32'd3);
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        chk("reset.state", 32'(state), 32'd0);
        chk("reset.lives", 32'(lives), 32'd3);
        chk("reset.streak", 32'(streak), 32'd0);
        chk("reset.countdown", 32'(countdown), 32'd0);
        chk("reset.best", 32'(best_bcd), 32'd0);
        chk("reset.pulses", 32'({running, score_inc, score_clear}), 32'd0);

        // Start, countdown 3,2,1,0, five hits, then misses on ticks 2,4,6.
        add(1,0,0,0, 1,3,3,0,0,1); add(0,0,0,0, 1,3,3,0,0,0);
        add(0,1,0,0, 1,2,3,0,0,0); add(0,0,0,0, 1,2,3,0,0,0);
        add(0,1,0,0, 1,1,3,0,0,0); add(0,0,0,0, 1,1,3,0,0,0);
        add(0,1,0,0, 2,0,3,0,0,0); add(0,0,0,0, 2,0,3,0,0,0);
        for (int k = 1; k <= 5; k++) begin
            add(0,1,1,0, 2,0,3,k,1,0); add(0,0,0,0, 2,0,3,k,0,0);
        end
        add(0,1,1,0, 2,0,3,6,1,0); add(0,0,0,0, 2,0,3,6,0,0);
        add(0,1,0,0, 2,0,2,0,0,0); add(0,0,0,0, 2,0,2,0,0,0);
        add(0,1,1,0, 2,0,2,1,1,0); add(0,0,0,0, 2,0,2,1,0,0);
        add(0,1,0,0, 2,0,1,0,0,0); add(0,0,0,0, 2,0,1,0,0,0);
        add(0,1,1,0, 2,0,1,1,1,0); add(0,0,0,0, 2,0,1,1,0,0);
        add(0,1,0,0, 3,0,0,0,0,0); add(0,0,0,0, 3,0,0,0,0,0);
        foreach (tbl[i]) begin
            cyc(0, tbl[i].st, tbl[i].bt, tbl[i].kh, tbl[i].se);
            chk($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].e_state));
            chk($sformatf("tbl%0d.countdown", i), 32'(countdown), 32'(tbl[i].e_cd));
            chk($sformatf("tbl%0d.lives", i), 32'(lives), 32'(tbl[i].e_lives));
            chk($sformatf("tbl%0d.streak", i), 32'(streak), 32'(tbl[i].e_streak));
            chk($sformatf("tbl%0d.inc", i), 32'(score_inc), 32'(tbl[i].e_inc));
            chk($sformatf("tbl%0d.clear", i), 32'(score_clear), 32'(tbl[i].e_clr));
            chk($sformatf("tbl%0d.running", i), 32'(running), 32'(tbl[i].e_state == 2));
        end
        cyc(0, 0, 0, 0, 0);
        chk("t3.best_after_8_hits", 32'(best_bcd), 32'h0008);

        // Best score keeps the maximum; update lands two edges after game over.
        play_to_over(16'h0120);
        cyc(0, 0, 0, 0, 0);
        chk("t4.best_0120", 32'(best_bcd), 32'h0120);
        play_to_over(16'h0090);
        cyc(0, 0, 0, 0, 0);
        chk("t4.best_keeps_0120", 32'(best_bcd), 32'h0120);
        play_to_over(16'h1000);
        chk("t4.best_not_yet", 32'(best_bcd), 32'h0120);
        cyc(0, 0, 0, 0, 0);
        chk("t4.best_1000", 32'(best_bcd), 32'h1000);
        use_force = 1'b0;

        // start held high throughout; song_end with a hit on the same tick.
        cyc(0, 1, 0, 0, 0);
        repeat (3) begin cyc(0, 1, 1, 0, 0); cyc(0, 1, 0, 0, 0); end
        cyc(0, 1, 0, 0, 0);
        chk("t5.no_restart_playing", 32'(state), 32'd2);
        chk("t5.no_clear_playing", 32'(score_clear), 32'd0);
        cyc(0, 1, 1, 1, 1);
        chk("t5.inc_with_song_end", 32'(score_inc), 32'd1);
        chk("t5.game_over", 32'(state), 32'd3);
        cyc(0, 1, 0, 0, 0);
        chk("t5.restart_from_over", 32'(state), 32'd1);
        chk("t5.clear_pulse", 32'({score_inc, score_clear}), 32'b01);

        // Streak saturation, then reset mid-streak on a hitting tick.
        repeat (3) begin cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0); end
        repeat (260) begin cyc(0, 0, 1, 1, 0); cyc(0, 0, 0, 0, 0); end
        chk("t6.streak_saturated", 32'(streak), 32'd255);
        cyc(1, 0, 1, 1, 0);
        chk("t6.reset_state", 32'(state), 32'd0);
        chk("t6.reset_lives", 32'(lives), 32'd3);
        chk("t6.reset_streak", 32'(streak), 32'd0);
        chk("t6.reset_best", 32'(best_bcd), 32'd0);
        chk("t6.reset_no_inc", 32'(score_inc), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t6.no_late_inc", 32'(score_inc), 32'd0);

        // Randomized play; ticks never on back-to-back cycles.
        begin
            int last_bt;
            int r, s, bt, kh, se;
            last_bt = 0;
            for (int i = 0; i < 3000; i++) begin
                r  = ($urandom_range(0, 499) == 0) ? 1 : 0;
                s  = ($urandom_range(0, 7) == 0) ? 1 : 0;
                bt = (last_bt == 0 && $urandom_range(0, 2) == 0) ? 1 : 0;
                kh = ($urandom_range(0, 3) != 0) ? 1 : 0;
                se = ($urandom_range(0, 59) == 0) ? 1 : 0;
                last_bt = bt;
                cyc(r, s, bt, kh, se);
                if (score_inc && score_clear) chk("rand.pulse_overlap", 32'd1, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
